// File: rtl/rs_board_reset_trip_ctrl_pkg.sv
// Shared types and helpers for the board reset / HBM trip conditioning block.
package rs_board_ctrl_pkg;

  typedef enum logic [1:0] {
    StAssert   = 2'd0,
    StDebounce = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } state_t;

  // Counter width for a terminal count, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rs_board_reset_trip_ctrl_if.sv
// Pin-side signal bundle of the board reset / trip controller.
interface rs_board_reset_trip_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             pcie_perstn_in;
  logic             cattrip_in;
  logic             cattrip_clr;
  logic             perstn_out;
  logic             cattrip_out;
  logic [CNT_W-1:0] trip_count;
  logic [1:0]       state_o;

  modport master (
    output pcie_perstn_in,
    output cattrip_in,
    output cattrip_clr,
    input  perstn_out,
    input  cattrip_out,
    input  trip_count,
    input  state_o
  );

  modport slave (
    input  pcie_perstn_in,
    input  cattrip_in,
    input  cattrip_clr,
    output perstn_out,
    output cattrip_out,
    output trip_count,
    output state_o
  );
endinterface

// File: rtl/rs_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module rs_bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rs_board_reset_trip_ctrl.sv
// Conditions PCIe PERST# into a debounced, stretched reset and latches HBM catastrophic trips.
module rs_board_reset_trip_ctrl
  import rs_board_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1024,
  parameter int unsigned RESET_HOLD_CYCLES = 256,
  parameter int unsigned CNT_W             = 16
) (
  input logic                        ap_clk,
  input logic                        ap_rst_n,
  rs_board_reset_trip_ctrl_if.slave  pins
);

  localparam int unsigned DebW  = clog2_min1(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = clog2_min1(RESET_HOLD_CYCLES);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

  logic perst_s;
  logic trip_s;

  rs_bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_perst_sync (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .d_i      (pins.pcie_perstn_in),
    .q_o      (perst_s)
  );

  rs_bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_trip_sync (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .d_i      (pins.cattrip_in),
    .q_o      (trip_s)
  );

  logic             trip_s_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] trip_cnt_q, trip_cnt_d;
  logic             trip_rise;
  logic             run_ok;

  state_t           state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             perstn_q;

  assign trip_rise = trip_s & ~trip_s_q;
  // A trip seen on this edge blocks release immediately, so assertion is not delayed by sticky_q.
  assign run_ok    = perst_s & ~(sticky_q | trip_rise);

  always_comb begin
    sticky_d   = sticky_q;
    trip_cnt_d = trip_cnt_q;
    if (trip_rise) begin
      sticky_d = 1'b1;
      if (trip_cnt_q != {CNT_W{1'b1}}) begin
        trip_cnt_d = trip_cnt_q + 1'b1;
      end
    end else if (pins.cattrip_clr && !trip_s) begin
      sticky_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StAssert: begin
        if (run_ok) begin
          state_d   = StDebounce;
          deb_cnt_d = '0;
        end
      end
      StDebounce: begin
        if (!run_ok) begin
          state_d = StAssert;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (!run_ok) begin
          state_d = StAssert;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!run_ok) begin
          state_d = StAssert;
        end
      end
      default: state_d = StAssert;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      trip_s_q   <= 1'b0;
      sticky_q   <= 1'b0;
      trip_cnt_q <= '0;
      state_q    <= StAssert;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      perstn_q   <= 1'b0;
    end else begin
      trip_s_q   <= trip_s;
      sticky_q   <= sticky_d;
      trip_cnt_q <= trip_cnt_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      perstn_q   <= (state_d == StRun);
    end
  end

  assign pins.perstn_out  = perstn_q;
  assign pins.cattrip_out = sticky_q;
  assign pins.trip_count  = trip_cnt_q;
  assign pins.state_o     = state_q;

endmodule

// File: tb/tb_rs_board_reset_trip_ctrl.sv
// Randomised scoreboard bench for rs_board_reset_trip_ctrl against a streak-based reference model.
module tb_rs_board_reset_trip_ctrl;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned DebCycles  = 8;
  localparam int unsigned HoldCycles = 4;
  localparam int unsigned CntW       = 2;
  localparam int          CntMax     = (1 << CntW) - 1;
  localparam int          HoldAt     = 1 + DebCycles;
  localparam int          RunAt      = 1 + DebCycles + HoldCycles;

  logic ap_clk = 1'b0;
  logic ap_rst_n;

  rs_board_reset_trip_ctrl_if #(.CNT_W(CntW)) pins ();

  rs_board_reset_trip_ctrl #(
    .SYNC_STAGES       (SyncStages),
    .DEBOUNCE_CYCLES   (DebCycles),
    .RESET_HOLD_CYCLES (HoldCycles),
    .CNT_W             (CntW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .pins     (pins)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic            perstn;
    logic            cattrip;
    logic [CntW-1:0] cnt;
    logic [1:0]      st;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: release happens once perst_s has been good for RunAt consecutive edges.
  logic [1:0] m_psync, m_tsync;
  logic       m_trip_prev, m_sticky, rst_prev;
  int         m_cnt, m_streak;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic p, input logic t, input logic c, input logic r);
    exp_t e;
    logic rise, good;
    @(negedge ap_clk);
    pins.pcie_perstn_in = p;
    pins.cattrip_in     = t;
    pins.cattrip_clr    = c;
    ap_rst_n            = r;
    if (!r && rst_prev) begin
      #1;
      chk("async_rst_perstn", int'(pins.perstn_out), 0);
      chk("async_rst_cattrip", int'(pins.cattrip_out), 0);
      chk("async_rst_count", int'(pins.trip_count), 0);
      chk("async_rst_state", int'(pins.state_o), 0);
    end
    rst_prev = r;
    if (!r) begin
      m_psync = '0; m_tsync = '0; m_trip_prev = 1'b0; m_sticky = 1'b0;
      m_cnt = 0; m_streak = 0;
    end else begin
      rise = m_tsync[1] && !m_trip_prev;
      good = m_psync[1] && !(m_sticky || rise);
      m_streak = good ? ((m_streak < RunAt) ? m_streak + 1 : m_streak) : 0;
      if (rise) begin
        m_sticky = 1'b1;
        if (m_cnt < CntMax) m_cnt++;
      end else if (c && !m_tsync[1]) begin
        m_sticky = 1'b0;
      end
      m_trip_prev = m_tsync[1];
      m_psync = {m_psync[0], p};
      m_tsync = {m_tsync[0], t};
    end
    e.perstn  = (m_streak >= RunAt);
    e.cattrip = m_sticky;
    e.cnt     = CntW'(m_cnt);
    e.st      = (m_streak == 0) ? 2'd0 : (m_streak < HoldAt) ? 2'd1 :
                (m_streak < RunAt) ? 2'd2 : 2'd3;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge ap_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("perstn_out", int'(pins.perstn_out), int'(e.perstn));
        chk("cattrip_out", int'(pins.cattrip_out), int'(e.cattrip));
        chk("trip_count", int'(pins.trip_count), int'(e.cnt));
        chk("state_o", int'(pins.state_o), int'(e.st));
      end
    end
  end

  initial begin : stimulus
    ap_rst_n = 1'b0;
    pins.pcie_perstn_in = 1'b0;
    pins.cattrip_in     = 1'b0;
    pins.cattrip_clr    = 1'b0;
    rst_prev = 1'b0;
    m_psync = '0; m_tsync = '0; m_trip_prev = 1'b0; m_sticky = 1'b0;
    m_cnt = 0; m_streak = 0;

    // Reset held with pins toggling
    for (int i = 0; i < 6; i++) step(1'(i & 1), 1'(~i & 1), 1'((i >> 1) & 1), 1'b0);
    // Clean release
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Glitch during debounce
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (18) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Short PERST# drop while running
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (18) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Trip while running, then software clear
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (16) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Five trips; the third one's rising edge coincides with a clear
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'(k == 2), 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (16) step(1'b1, 1'b0, 1'b0, 1'b1);
    // Random traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 29) == 0), 1'(!(i == 700 || i == 701)));
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge ap_clk);
    end
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
